// File: rtl/bp_fe_pkg.sv
// Shared front-end types for the branch-predictor update path.
// The entry struct is provided as a macro so each instance can size it to its own BHT index width.
`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV

`define BP_FE_BP_UPD_ENTRY_S(idx_width_mp) \
    struct packed { logic [idx_width_mp-1:0] idx; logic taken; }

package bp_fe_pkg;

    localparam int bht_idx_width_gp = 9;

    typedef `BP_FE_BP_UPD_ENTRY_S(bht_idx_width_gp) bp_fe_bp_upd_entry_s;

    function automatic logic dir_mismatch(input logic predicted, input logic actual);
        return predicted ^ actual;
    endfunction

endpackage

`endif

// File: rtl/bp_fe_bp_upd_fifo.sv
// Circular in-order storage with synchronous write, combinational head read,
// and count-based full/empty; clear empties the queue by snapping rd_ptr to wr_ptr.
module bp_fe_bp_upd_fifo
    import bp_fe_pkg::*;
#(
    parameter int width_p     = 10,
    parameter int els_p       = 8,
    parameter int ptr_width_p = $clog2(els_p),
    parameter int cnt_width_p = $clog2(els_p + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [width_p-1:0]     wdata,
    output logic [width_p-1:0]     head,
    output logic                   full,
    output logic                   empty,
    output logic [cnt_width_p-1:0] count
);

    localparam logic [cnt_width_p-1:0] cnt_full_lp = cnt_width_p'(els_p);
    localparam logic [cnt_width_p-1:0] cnt_one_lp  = cnt_width_p'(1'b1);
    localparam logic [ptr_width_p-1:0] ptr_one_lp  = ptr_width_p'(1'b1);

    logic [width_p-1:0]     mem_r [els_p];
    logic [ptr_width_p-1:0] rd_ptr_r;
    logic [ptr_width_p-1:0] wr_ptr_r;
    logic [cnt_width_p-1:0] count_r;

    assign head  = mem_r[rd_ptr_r];
    assign full  = (count_r == cnt_full_lp);
    assign empty = (count_r == {cnt_width_p{1'b0}});
    assign count = count_r;

    // Entry storage: written on push, intentionally not reset.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; pointer wrap relies on els_p being a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {ptr_width_p{1'b0}};
            wr_ptr_r <= {ptr_width_p{1'b0}};
            count_r  <= {cnt_width_p{1'b0}};
        end else if (clear) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= {cnt_width_p{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + ptr_one_lp;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + ptr_one_lp;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + cnt_one_lp;
                2'b01:   count_r <= count_r - cnt_one_lp;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/bp_fe_bp_update_queue.sv
// Tracks issued predictions in program order and turns each backend resolution
// into a registered predictor update; a mispredict or flush squashes younger entries.
module bp_fe_bp_update_queue
    import bp_fe_pkg::*;
#(
    parameter int  bht_idx_width_p = 9,
    parameter int  queue_els_p     = 8,
    localparam int ptr_width_lp    = $clog2(queue_els_p),
    localparam int cnt_width_lp    = $clog2(queue_els_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       pred_v_i,
    input  logic [bht_idx_width_p-1:0] pred_idx_i,
    input  logic                       pred_taken_i,
    output logic                       pred_ready_o,
    input  logic                       res_v_i,
    input  logic                       res_taken_i,
    input  logic                       flush_i,
    output logic                       w_v_o,
    output logic [bht_idx_width_p-1:0] idx_w_o,
    output logic                       correct_o,
    output logic                       mispredict_o,
    output logic [cnt_width_lp-1:0]    count_o,
    output logic                       underflow_o
);

    typedef `BP_FE_BP_UPD_ENTRY_S(bht_idx_width_p) upd_entry_s;
    localparam int entry_width_lp = $bits(upd_entry_s);

    upd_entry_s                  wr_entry_s;
    upd_entry_s                  head_entry_s;
    logic [entry_width_lp-1:0]   head_bits_s;
    logic                        full_s;
    logic                        empty_s;
    logic                        push_s;
    logic                        pop_s;
    logic                        miss_s;
    logic                        kill_s;

    logic                        w_v_r;
    logic [bht_idx_width_p-1:0]  idx_w_r;
    logic                        correct_r;
    logic                        mispredict_r;
    logic                        underflow_r;

    bp_fe_bp_upd_fifo #(
        .width_p     (entry_width_lp),
        .els_p       (queue_els_p),
        .ptr_width_p (ptr_width_lp),
        .cnt_width_p (cnt_width_lp)
    ) fifo (
        .clk   (clk_i),
        .rst   (reset_i),
        .push  (push_s),
        .pop   (pop_s),
        .clear (kill_s),
        .wdata (wr_entry_s),
        .head  (head_bits_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_o)
    );

    // Handshake decode; a same-cycle push never survives a kill since it is on the wrong path.
    always_comb begin
        wr_entry_s.idx   = pred_idx_i;
        wr_entry_s.taken = pred_taken_i;
        head_entry_s     = upd_entry_s'(head_bits_s);
        pop_s            = res_v_i & ~empty_s;
        miss_s           = pop_s & dir_mismatch(head_entry_s.taken, res_taken_i);
        kill_s           = flush_i | miss_s;
        push_s           = pred_v_i & ~full_s & ~kill_s;
    end

    // Registered predictor-update port; index and verdict hold between updates.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            w_v_r        <= 1'b0;
            idx_w_r      <= {bht_idx_width_p{1'b0}};
            correct_r    <= 1'b0;
            mispredict_r <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            w_v_r        <= pop_s;
            mispredict_r <= miss_s;
            underflow_r  <= res_v_i & empty_s;
            if (pop_s) begin
                idx_w_r   <= head_entry_s.idx;
                correct_r <= ~dir_mismatch(head_entry_s.taken, res_taken_i);
            end
        end
    end

    assign pred_ready_o = ~full_s;
    assign w_v_o        = w_v_r;
    assign idx_w_o      = idx_w_r;
    assign correct_o    = correct_r;
    assign mispredict_o = mispredict_r;
    assign underflow_o  = underflow_r;

endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// Directed bench for the predictor update queue with a reference queue model and an update scoreboard.
module tb_bp_fe_bp_update_queue;

    logic       clk;
    logic       reset_i;
    logic       pred_v_i;
    logic [8:0] pred_idx_i;
    logic       pred_taken_i;
    logic       pred_ready_o;
    logic       res_v_i;
    logic       res_taken_i;
    logic       flush_i;
    logic       w_v_o;
    logic [8:0] idx_w_o;
    logic       correct_o;
    logic       mispredict_o;
    logic [3:0] count_o;
    logic       underflow_o;

    bp_fe_bp_update_queue dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .pred_v_i     (pred_v_i),
        .pred_idx_i   (pred_idx_i),
        .pred_taken_i (pred_taken_i),
        .pred_ready_o (pred_ready_o),
        .res_v_i      (res_v_i),
        .res_taken_i  (res_taken_i),
        .flush_i      (flush_i),
        .w_v_o        (w_v_o),
        .idx_w_o      (idx_w_o),
        .correct_o    (correct_o),
        .mispredict_o (mispredict_o),
        .count_o      (count_o),
        .underflow_o  (underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [8:0] idx; logic taken; } ent_t;
    typedef struct packed { logic [8:0] idx; logic corr; } upd_t;

    ent_t       mq[$];
    upd_t       sb[$];
    logic [8:0] exp_idx;
    logic       exp_corr;
    int         vectors;
    int         miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the reference model predicts every output for the following cycle.
    task automatic cycle(input bit pv, input logic [8:0] pidx, input bit ptk,
                         input bit rv, input bit rtk, input bit fl);
        bit   pop, mis, kill, push, uf, ready;
        ent_t h;
        upd_t u;
        ready = (mq.size() != 8);
        pop   = rv && (mq.size() != 0);
        h     = '0;
        if (pop) h = mq[0];
        mis   = pop && (h.taken != rtk);
        kill  = fl || mis;
        push  = pv && ready && !kill;
        uf    = rv && (mq.size() == 0);
        pred_v_i = pv; pred_idx_i = pidx; pred_taken_i = ptk;
        res_v_i = rv; res_taken_i = rtk; flush_i = fl;
        if (pop) begin
            sb.push_back('{idx: h.idx, corr: (h.taken == rtk)});
            exp_idx  = h.idx;
            exp_corr = (h.taken == rtk);
            void'(mq.pop_front());
        end
        if (kill) mq.delete();
        else if (push) mq.push_back('{idx: pidx, taken: ptk});
        @(posedge clk);
        #1;
        chk("w_v", w_v_o, pop);
        if (w_v_o === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL sb_underrun observed=w_v_o=1 expected=no_update");
            end else begin
                u = sb.pop_front();
                chk("upd_idx", idx_w_o, u.idx);
                chk("upd_correct", correct_o, u.corr);
            end
        end
        chk("idx_hold", idx_w_o, exp_idx);
        chk("correct_hold", correct_o, exp_corr);
        chk("mispredict", mispredict_o, mis);
        chk("underflow", underflow_o, uf);
        chk("count", count_o, mq.size());
        chk("ready", pred_ready_o, mq.size() != 8);
        pred_v_i = 1'b0; res_v_i = 1'b0; flush_i = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        exp_idx = 9'h000; exp_corr = 1'b0;
        reset_i = 1'b1; pred_v_i = 1'b0; pred_idx_i = 9'h000; pred_taken_i = 1'b0;
        res_v_i = 1'b0; res_taken_i = 1'b0; flush_i = 1'b0;
        #12;
        chk("rst_count", count_o, 0);
        chk("rst_ready", pred_ready_o, 1);
        chk("rst_w_v", w_v_o, 0);
        chk("rst_idx", idx_w_o, 0);
        chk("rst_underflow", underflow_o, 0);
        reset_i = 1'b0;

        // Asynchronous reset landing while an update is visible
        cycle(1, 9'h0A0, 1, 0, 0, 0);
        cycle(1, 9'h0A1, 0, 0, 0, 0);
        cycle(1, 9'h0A2, 1, 0, 0, 0);
        cycle(0, 9'h000, 0, 1, 1, 0);
        #2 reset_i = 1'b1;
        #1;
        chk("arst_w_v", w_v_o, 0);
        chk("arst_count", count_o, 0);
        chk("arst_ready", pred_ready_o, 1);
        chk("arst_idx", idx_w_o, 0);
        chk("arst_correct", correct_o, 0);
        chk("arst_mispredict", mispredict_o, 0);
        #1 reset_i = 1'b0;
        mq.delete(); sb.delete(); exp_idx = 9'h000; exp_corr = 1'b0;
        cycle(1, 9'h0AB, 1, 0, 0, 0);
        cycle(0, 9'h000, 0, 1, 1, 0);

        // In-order correct updates
        cycle(1, 9'h005, 1, 0, 0, 0);
        cycle(1, 9'h01A, 0, 0, 0, 0);
        cycle(0, 9'h000, 0, 1, 1, 0);
        cycle(0, 9'h000, 0, 1, 0, 0);
        cycle(0, 9'h000, 0, 0, 0, 0);

        // Mispredict squashes younger entries and the concurrent push
        cycle(1, 9'h010, 1, 0, 0, 0);
        cycle(1, 9'h011, 1, 0, 0, 0);
        cycle(1, 9'h012, 0, 0, 0, 0);
        cycle(1, 9'h013, 1, 1, 0, 0);
        cycle(0, 9'h000, 0, 1, 1, 0);

        // Fill, overflow attempt, then concurrent push/resolve across pointer wrap
        for (int i = 0; i < 8; i++) cycle(1, 9'(9'h040 + i), i[0], 0, 0, 0);
        cycle(1, 9'h1FF, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            cycle(1, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), 1, mq[0].taken, 0);
        for (int i = 0; i < 10; i++)
            if (mq.size() != 0) cycle(0, 9'h000, 0, 1, mq[0].taken, 0);

        // External flush alone, then flush together with a resolve
        for (int i = 0; i < 4; i++) cycle(1, 9'(9'h080 + i), 1, 0, 0, 0);
        cycle(0, 9'h000, 0, 0, 0, 1);
        cycle(1, 9'h0C0, 0, 0, 0, 0);
        cycle(1, 9'h0C1, 1, 0, 0, 0);
        cycle(0, 9'h000, 0, 1, 0, 1);
        cycle(0, 9'h000, 0, 0, 0, 0);

        // Underflow with a same-cycle push that must still land
        cycle(1, 9'h007, 0, 1, 0, 0);
        cycle(0, 9'h000, 0, 1, 0, 0);
        cycle(0, 9'h000, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bp_fe_bp_update_queue.md
Name: bp_fe_bp_update_queue

Overview:
- Feedback end of the branch-predictor read/update interface.
- Records every issued prediction (BHT index, predicted direction) in an in-order FIFO.
- Pops the oldest entry when the backend resolves a branch, and drives the predictor's update write port (w_v/idx_w/correct).
- Squashes all younger in-flight predictions on a misprediction or an external flush.

Parameters:
- bht_idx_width_p, 9: BHT index width; must match the predictor instance.
- queue_els_p, 8: in-flight prediction capacity; power of two, ≥2.
- ptr_width_lp (localparam), $clog2(queue_els_p): read/write pointer width.
- cnt_width_lp (localparam), $clog2(queue_els_p+1): occupancy counter width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  asynchronous, active-high reset
- pred_v_i  in  1  prediction issued this cycle
- pred_idx_i  in  bht_idx_width_p  BHT index used for the prediction
- pred_taken_i  in  1  predicted direction
- pred_ready_o  out  1  queue can accept a prediction (not full)
- res_v_i  in  1  oldest outstanding branch resolved this cycle (program order)
- res_taken_i  in  1  actual branch direction
- flush_i  in  1  discard all outstanding entries
- w_v_o  out  1  predictor update strobe (to predictor w_v_i)
- idx_w_o  out  bht_idx_width_p  update index (to idx_w_i)
- correct_o  out  1  1 = prediction matched outcome (to correct_i)
- mispredict_o  out  1  1-cycle pulse; resolved branch was mispredicted
- count_o  out  cnt_width_lp  current occupancy
- underflow_o  out  1  1-cycle pulse; res_v_i arrived while queue empty

Behaviour:
- Reset (async, active-high): rd/wr pointers=0, count=0, w_v_o=0, idx_w_o=0, correct_o=0, mispredict_o=0, underflow_o=0, pred_ready_o=1. Entry storage is not reset.
- push = pred_v_i & pred_ready_o & ~kill.
  - Writes {pred_idx_i, pred_taken_i} at wr_ptr; wr_ptr increments mod queue_els_p.
  - pred_v_i while full is dropped silently; the issuer must honour pred_ready_o.
- pred_ready_o = (count != queue_els_p). It is combinational from state only, and is not relieved by a same-cycle pop.
- pop = res_v_i & (count != 0). Reads the head entry; rd_ptr increments.
  - res_v_i with count==0: no pop, no write; underflow_o=1 next cycle.
- Update outputs are registered, 1-cycle latency after pop:
  - w_v_o=pop
  - idx_w_o=head.idx (held when w_v_o=0)
  - correct_o=(head.taken==res_taken_i)
  - mispredict_o=pop & (head.taken!=res_taken_i)
- kill = flush_i | (pop & head.taken!=res_taken_i).
  - On kill, next state is empty: count=0, rd_ptr=wr_ptr.
  - Any same-cycle push is dropped, because a mispredict-path prediction is squashed.
  - On kill, the popped entry's update is still emitted normally.
- flush_i without res_v_i: no update write; queue empties next cycle.
- Simultaneous push & pop (no kill): count unchanged; pointers both advance.
- Push into empty queue plus same-cycle res_v_i: no bypass. This is an underflow; the push completes.
- Pointer wrap is modular; full/empty are determined by count, not by pointer compare.
- count_o is the registered count.

Decomposition:
- bp_fe_pkg gains typedef bp_fe_bp_upd_entry_s {logic [bht_idx_width_p-1:0] idx; logic taken;}, via a width-parameterised struct macro consistent with the package.
- One natural sub-module: bp_fe_bp_upd_fifo. It provides circular storage with pointers and count, a synchronous write, and a combinational head read, with push/pop/clear inputs and full/empty/count outputs.
- The top level holds the compare, kill, and output registers.

Test Plan:
- Reset mid-operation: push 3 entries, assert reset_i asynchronously between edges. Expect all outputs zero immediately and count_o=0; the first push after release lands at slot 0.
- In-order correct updates: push (idx 0x05,T), (0x1A,N); resolve T then N. Expect w_v_o pulses on consecutive cycles with idx_w_o=0x05 then 0x1A, correct_o=1 both times, mispredict_o=0, count_o ending at 0.
- Mispredict squash: push (0x10,T), (0x11,T), (0x12,N); resolve N with a simultaneous push (0x13,T). Expect next cycle w_v_o=1, idx_w_o=0x10, correct_o=0, mispredict_o=1, count_o=0. The push is dropped and the next res_v_i gives underflow_o=1.
- Full/wrap: push 8 entries. pred_ready_o=0 after the 8th; a 9th pred_v_i is ignored (count_o stays 8). Then do 20 cycles of concurrent push+correct-resolve. Expect idx_w_o to follow push order across pointer wrap.
- External flush: with 4 entries queued, assert flush_i alone. Expect no w_v_o and count_o=0 next cycle. A flush_i+res_v_i cycle emits exactly one update for the head entry.
- Underflow: res_v_i on empty queue together with push (0x07,N). Expect underflow_o=1, w_v_o=0, count_o=1; the next resolve N yields idx_w_o=0x07, correct_o=1.
